// File: rtl/aukv_wb_arbiter.sv
// aukv_wb_arbiter
//
// Shares one Wishbone classic master port between the aukv core's fetch
// (code) port and its load/store (data) port. Each port latches one request
// at a time. A round-robin arbiter picks which pending request goes on the
// bus next. Each completion returns a single-cycle valid pulse together with
// the read data. A watchdog aborts any bus cycle whose ack never arrives.
//
// Ports:
//   clk_core, rst_core         core clock, synchronous active-high reset
//   i_code_en / i_code_addr    fetch request strobe and address
//   o_code_data / o_code_valid fetch data and one-cycle completion pulse
//   i_data_en, i_data_we, i_data_addr, i_data_wdata, i_data_strobe
//                              load/store request strobe and request fields
//   o_data_rdata / o_data_valid load data and one-cycle completion pulse
//   o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr, o_wb_data
//                              Wishbone master outputs
//   i_wb_data, i_wb_ack        Wishbone read data and acknowledge
//   o_timeout                  sticky flag, set when the watchdog aborts a transfer
module aukv_wb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    i_code_en,
    input  logic [ADDR_WIDTH-1:0]   i_code_addr,
    output logic [DATA_WIDTH-1:0]   o_code_data,
    output logic                    o_code_valid,
    input  logic                    i_data_en,
    input  logic                    i_data_we,
    input  logic [ADDR_WIDTH-1:0]   i_data_addr,
    input  logic [DATA_WIDTH-1:0]   i_data_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_data_strobe,
    output logic [DATA_WIDTH-1:0]   o_data_rdata,
    output logic                    o_data_valid,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    output logic [ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic                    i_wb_ack,
    output logic                    o_timeout
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUS_CODE = 2'd1;
    localparam logic [1:0] S_BUS_DATA = 2'd2;

    localparam logic GRANT_CODE = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  code_pend;
    logic [ADDR_WIDTH-1:0] code_addr_q;
    logic                  data_pend;
    logic                  data_we_q;
    logic [ADDR_WIDTH-1:0] data_addr_q;
    logic [DATA_WIDTH-1:0] data_wdata_q;
    logic [SEL_WIDTH-1:0]  data_strobe_q;
    logic [CNT_WIDTH-1:0]  wd_cnt;

    logic code_req;
    logic data_req;
    logic wd_expired;

    // A strobe arriving this cycle counts for arbitration right away. This
    // saves one cycle between a request and the start of its bus cycle.
    assign code_req = code_pend | i_code_en;
    assign data_req = data_pend | i_data_en;

    // A watchdog limit of zero disables the abort path completely.
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));

    // Request capture, arbitration, bus sequencing and completion.
    // A pending flag stays set while its request is on the bus. A second
    // strobe from the same port is therefore ignored until the completion edge.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state         <= S_IDLE;
            last_grant    <= GRANT_CODE;
            code_pend     <= 1'b0;
            code_addr_q   <= '0;
            data_pend     <= 1'b0;
            data_we_q     <= 1'b0;
            data_addr_q   <= '0;
            data_wdata_q  <= '0;
            data_strobe_q <= '0;
            wd_cnt        <= '0;
            o_code_data   <= '0;
            o_code_valid  <= 1'b0;
            o_data_rdata  <= '0;
            o_data_valid  <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_code_valid <= 1'b0;
            o_data_valid <= 1'b0;

            if (i_code_en && !code_pend) begin
                code_pend   <= 1'b1;
                code_addr_q <= i_code_addr;
            end
            if (i_data_en && !data_pend) begin
                data_pend     <= 1'b1;
                data_we_q     <= i_data_we;
                data_addr_q   <= i_data_addr;
                data_wdata_q  <= i_data_wdata;
                data_strobe_q <= i_data_strobe;
            end

            case (state)
                S_IDLE: begin
                    wd_cnt <= '0;
                    // On a tie, the port that was not served last goes next.
                    if (code_req && (!data_req || last_grant == GRANT_DATA)) begin
                        state <= S_BUS_CODE;
                    end else if (data_req) begin
                        state <= S_BUS_DATA;
                    end
                end
                S_BUS_CODE: begin
                    // If ack and the watchdog limit coincide, ack wins and
                    // the transfer completes normally.
                    if (i_wb_ack) begin
                        o_code_data  <= i_wb_data;
                        o_code_valid <= 1'b1;
                        code_pend    <= 1'b0;
                        last_grant   <= GRANT_CODE;
                        state        <= S_IDLE;
                    end else if (wd_expired) begin
                        o_code_data  <= '0;
                        o_code_valid <= 1'b1;
                        o_timeout    <= 1'b1;
                        code_pend    <= 1'b0;
                        last_grant   <= GRANT_CODE;
                        state        <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_BUS_DATA: begin
                    if (i_wb_ack) begin
                        o_data_rdata <= data_we_q ? '0 : i_wb_data;
                        o_data_valid <= 1'b1;
                        data_pend    <= 1'b0;
                        last_grant   <= GRANT_DATA;
                        state        <= S_IDLE;
                    end else if (wd_expired) begin
                        o_data_rdata <= '0;
                        o_data_valid <= 1'b1;
                        o_timeout    <= 1'b1;
                        data_pend    <= 1'b0;
                        last_grant   <= GRANT_DATA;
                        state        <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The Wishbone outputs are decoded from the registered state, so they
    // never glitch. They stay at zero while no bus cycle is in progress.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_sel  = '0;
        o_wb_addr = '0;
        o_wb_data = '0;
        case (state)
            S_BUS_CODE: begin
                o_wb_cyc  = 1'b1;
                o_wb_stb  = 1'b1;
                o_wb_sel  = '1;
                o_wb_addr = code_addr_q;
            end
            S_BUS_DATA: begin
                o_wb_cyc  = 1'b1;
                o_wb_stb  = 1'b1;
                o_wb_we   = data_we_q;
                o_wb_sel  = data_we_q ? data_strobe_q : '1;
                o_wb_addr = data_addr_q;
                o_wb_data = data_wdata_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aukv_wb_arbiter.sv
// tb_aukv_wb_arbiter
//
// Directed bench for aukv_wb_arbiter, built with an 8-cycle watchdog.
// The bench drives and samples each signal 1 time unit after the rising
// clock edge. At that point the registered outputs show the edge that has
// just passed, and any inputs set now take effect at the next edge.
module tb_aukv_wb_arbiter;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        i_code_en;
    logic [31:0] i_code_addr;
    logic [31:0] o_code_data;
    logic        o_code_valid;
    logic        i_data_en;
    logic        i_data_we;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wdata;
    logic [3:0]  i_data_strobe;
    logic [31:0] o_data_rdata;
    logic        o_data_valid;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    aukv_wb_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_core     (clk_core),
        .rst_core     (rst_core),
        .i_code_en    (i_code_en),
        .i_code_addr  (i_code_addr),
        .o_code_data  (o_code_data),
        .o_code_valid (o_code_valid),
        .i_data_en    (i_data_en),
        .i_data_we    (i_data_we),
        .i_data_addr  (i_data_addr),
        .i_data_wdata (i_data_wdata),
        .i_data_strobe(i_data_strobe),
        .o_data_rdata (o_data_rdata),
        .o_data_valid (o_data_valid),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_sel     (o_wb_sel),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .i_wb_data    (i_wb_data),
        .i_wb_ack     (i_wb_ack),
        .o_timeout    (o_timeout)
    );

    always #5 clk_core = ~clk_core;

    // Advance the given number of rising edges, then wait 1 time unit so the
    // registered outputs have settled.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_core);
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_core      = 1'b1;
        i_code_en     = 1'b0;
        i_code_addr   = '0;
        i_data_en     = 1'b0;
        i_data_we     = 1'b0;
        i_data_addr   = '0;
        i_data_wdata  = '0;
        i_data_strobe = '0;
        i_wb_data     = '0;
        i_wb_ack      = 1'b0;
        applyStimulus(2);
        rst_core = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        checkOutput("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        checkOutput("rst_code_valid", {31'd0, o_code_valid}, 32'd0);
        checkOutput("rst_data_valid", {31'd0, o_data_valid}, 32'd0);
        checkOutput("rst_timeout", {31'd0, o_timeout}, 32'd0);
        checkOutput("rst_code_data", o_code_data, 32'd0);
        checkOutput("rst_wb_addr", o_wb_addr, 32'd0);

        // Single fetch. Ack arrives 2 cycles after stb is first seen.
        $display("[TB] single fetch");
        i_wb_data   = 32'hFFFF_FFFF;
        i_wb_ack    = 1'b1;
        applyStimulus(1);
        checkOutput("idle_ack_ignored", {31'd0, o_code_valid}, 32'd0);
        i_wb_ack    = 1'b0;
        i_code_en   = 1'b1;
        i_code_addr = 32'h100;
        applyStimulus(1);
        i_code_en = 1'b0;
        checkOutput("f_cyc", {31'd0, o_wb_cyc}, 32'd1);
        checkOutput("f_stb", {31'd0, o_wb_stb}, 32'd1);
        checkOutput("f_addr", o_wb_addr, 32'h100);
        checkOutput("f_we", {31'd0, o_wb_we}, 32'd0);
        checkOutput("f_sel", {28'd0, o_wb_sel}, 32'hF);
        applyStimulus(2);
        checkOutput("f_cyc_wait", {31'd0, o_wb_cyc}, 32'd1);
        checkOutput("f_valid_wait", {31'd0, o_code_valid}, 32'd0);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h0000_0013;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        i_wb_data = 32'hBAD0_BAD0;
        checkOutput("f_valid", {31'd0, o_code_valid}, 32'd1);
        checkOutput("f_data", o_code_data, 32'h0000_0013);
        checkOutput("f_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
        applyStimulus(1);
        checkOutput("f_valid_once", {31'd0, o_code_valid}, 32'd0);
        checkOutput("f_data_hold", o_code_data, 32'h0000_0013);

        // Store with an immediate ack. The read data on the bus must not reach rdata.
        $display("[TB] store");
        i_data_en     = 1'b1;
        i_data_we     = 1'b1;
        i_data_addr   = 32'h2004;
        i_data_wdata  = 32'hA5A5_A5A5;
        i_data_strobe = 4'h3;
        applyStimulus(1);
        i_data_en = 1'b0;
        checkOutput("s_cyc", {31'd0, o_wb_cyc}, 32'd1);
        checkOutput("s_we", {31'd0, o_wb_we}, 32'd1);
        checkOutput("s_sel", {28'd0, o_wb_sel}, 32'h3);
        checkOutput("s_addr", o_wb_addr, 32'h2004);
        checkOutput("s_wdata", o_wb_data, 32'hA5A5_A5A5);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'hDEAD_BEEF;
        applyStimulus(1);
        i_wb_ack = 1'b0;
        checkOutput("s_valid", {31'd0, o_data_valid}, 32'd1);
        checkOutput("s_rdata", o_data_rdata, 32'd0);
        checkOutput("s_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
        applyStimulus(1);
        checkOutput("s_valid_once", {31'd0, o_data_valid}, 32'd0);

        // Contention right after reset: the expected grant order is DATA,
        // CODE, DATA, CODE.
        $display("[TB] contention");
        rst_core = 1'b1;
        applyStimulus(1);
        rst_core    = 1'b0;
        i_code_en   = 1'b1;
        i_code_addr = 32'h80;
        i_data_en   = 1'b1;
        i_data_we   = 1'b0;
        i_data_addr = 32'h40;
        applyStimulus(1);
        i_code_en = 1'b0;
        i_data_en = 1'b0;
        checkOutput("c1_addr", o_wb_addr, 32'h40);
        checkOutput("c1_sel", {28'd0, o_wb_sel}, 32'hF);
        checkOutput("c1_we", {31'd0, o_wb_we}, 32'd0);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h11;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        checkOutput("c1_rdata", o_data_rdata, 32'h11);
        checkOutput("c1_idle", {31'd0, o_wb_cyc}, 32'd0);
        i_data_en = 1'b1;
        applyStimulus(1);
        i_data_en = 1'b0;
        checkOutput("c2_cyc", {31'd0, o_wb_cyc}, 32'd1);
        checkOutput("c2_addr", o_wb_addr, 32'h80);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h22;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        checkOutput("c2_code_data", o_code_data, 32'h22);
        checkOutput("c2_code_valid", {31'd0, o_code_valid}, 32'd1);
        checkOutput("c2_idle", {31'd0, o_wb_cyc}, 32'd0);
        i_code_en   = 1'b1;
        i_code_addr = 32'h84;
        applyStimulus(1);
        i_code_en = 1'b0;
        checkOutput("c3_addr", o_wb_addr, 32'h40);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h33;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        checkOutput("c3_rdata", o_data_rdata, 32'h33);
        checkOutput("c3_idle", {31'd0, o_wb_cyc}, 32'd0);
        applyStimulus(1);
        checkOutput("c4_addr", o_wb_addr, 32'h84);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h44;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        checkOutput("c4_code_data", o_code_data, 32'h44);

        // Load that never receives an ack. Cycles with watchdog counts 0..8
        // keep cyc high, and the abort takes effect at the following edge.
        $display("[TB] timeout");
        i_data_en   = 1'b1;
        i_data_we   = 1'b0;
        i_data_addr = 32'h3000;
        applyStimulus(1);
        i_data_en = 1'b0;
        checkOutput("t_cyc_start", {31'd0, o_wb_cyc}, 32'd1);
        applyStimulus(8);
        checkOutput("t_cyc_last", {31'd0, o_wb_cyc}, 32'd1);
        checkOutput("t_flag_before", {31'd0, o_timeout}, 32'd0);
        applyStimulus(1);
        checkOutput("t_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
        checkOutput("t_valid", {31'd0, o_data_valid}, 32'd1);
        checkOutput("t_rdata", o_data_rdata, 32'd0);
        checkOutput("t_flag", {31'd0, o_timeout}, 32'd1);
        applyStimulus(3);
        checkOutput("t_flag_sticky", {31'd0, o_timeout}, 32'd1);
        checkOutput("t_valid_once", {31'd0, o_data_valid}, 32'd0);

        // An ack that arrives in the watchdog-limit cycle counts as a normal completion.
        $display("[TB] ack on timeout cycle");
        rst_core = 1'b1;
        applyStimulus(1);
        rst_core = 1'b0;
        checkOutput("a_flag_cleared", {31'd0, o_timeout}, 32'd0);
        i_data_en   = 1'b1;
        i_data_addr = 32'h3004;
        applyStimulus(1);
        i_data_en = 1'b0;
        applyStimulus(8);
        checkOutput("a_cyc_last", {31'd0, o_wb_cyc}, 32'd1);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h1234;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        checkOutput("a_valid", {31'd0, o_data_valid}, 32'd1);
        checkOutput("a_rdata", o_data_rdata, 32'h1234);
        checkOutput("a_flag", {31'd0, o_timeout}, 32'd0);

        // Reset asserted in the middle of a code bus cycle.
        $display("[TB] reset mid-cycle");
        i_code_en   = 1'b1;
        i_code_addr = 32'h500;
        applyStimulus(1);
        i_code_en = 1'b0;
        checkOutput("r_cyc_before", {31'd0, o_wb_cyc}, 32'd1);
        rst_core = 1'b1;
        applyStimulus(1);
        rst_core = 1'b0;
        checkOutput("r_cyc", {31'd0, o_wb_cyc}, 32'd0);
        checkOutput("r_stb", {31'd0, o_wb_stb}, 32'd0);
        checkOutput("r_valid", {31'd0, o_code_valid}, 32'd0);
        applyStimulus(1);
        checkOutput("r_pend_lost", {31'd0, o_wb_cyc}, 32'd0);
        checkOutput("r_no_valid", {31'd0, o_code_valid}, 32'd0);
        i_code_en   = 1'b1;
        i_code_addr = 32'h600;
        applyStimulus(1);
        i_code_en = 1'b0;
        checkOutput("r_new_addr", o_wb_addr, 32'h600);
        i_wb_ack  = 1'b1;
        i_wb_data = 32'h77;
        applyStimulus(1);
        i_wb_ack  = 1'b0;
        checkOutput("r_new_valid", {31'd0, o_code_valid}, 32'd1);
        checkOutput("r_new_data", o_code_data, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aukv_wb_arbiter.md
Name: aukv_wb_arbiter

Overview:
Shares one Wishbone classic master port between the aukv core's code-memory port (fetch) and data-memory port (load/store). It sits between the aukv core and the core_* Wishbone bus of processorci_top when the second memory is disabled. Each requester gets a one-cycle valid pulse with its read data. A watchdog terminates transfers whose ack never arrives.

Parameters:
ADDR_WIDTH, 32, width of code/data/Wishbone addresses
DATA_WIDTH, 32, width of data buses; sel width = DATA_WIDTH/8
TIMEOUT_CYCLES, 255, max cycles waiting for ack before abort; 0 disables the watchdog

Ports:
clk_core  in  1  core clock; all logic on rising edge
rst_core  in  1  synchronous, active-high reset
i_code_en  in  1  fetch request strobe
i_code_addr  in  ADDR_WIDTH  fetch address
o_code_data  out  DATA_WIDTH  fetch data, valid with o_code_valid
o_code_valid  out  1  one-cycle fetch completion pulse
i_data_en  in  1  load/store request strobe
i_data_we  in  1  1 = store
i_data_addr  in  ADDR_WIDTH  load/store address
i_data_wdata  in  DATA_WIDTH  store data
i_data_strobe  in  DATA_WIDTH/8  store byte enables
o_data_rdata  out  DATA_WIDTH  load data, valid with o_data_valid
o_data_valid  out  1  one-cycle load/store completion pulse
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
o_wb_sel  out  DATA_WIDTH/8  byte selects
o_wb_addr  out  ADDR_WIDTH  address
o_wb_data  out  DATA_WIDTH  write data
i_wb_data  in  DATA_WIDTH  read data
i_wb_ack  in  1  Wishbone ack
o_timeout  out  1  sticky flag, set on any watchdog abort

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Pending flags cleared. Last-grant = CODE.
- Capture:
  - i_code_en high while no code request is pending or active: set code_pend and latch the address.
  - i_data_en works the same for the data port; it latches we, addr, wdata and strobe.
  - i_*_en asserted while that port is already pending or active is ignored.
- FSM IDLE -> GRANT. Arbitration is evaluated on pending flags, including a request captured in the same cycle.
  - Only one port pending: grant it.
  - Both pending: grant the port not granted last (round-robin). After reset, DATA wins the first tie.
- Bus cycle:
  - FSM enters BUS_CODE or BUS_DATA and drives cyc = stb = 1 from the latched request until ack.
  - Code cycles drive we = 0 and sel = all ones.
  - Data stores drive sel = latched strobe. Data loads drive sel = all ones.
- Termination:
  - On the cycle i_wb_ack = 1: deassert cyc/stb next cycle and register i_wb_data into that port's rdata.
  - Pulse that port's valid for exactly 1 cycle; for stores, rdata = 0.
  - Clear the pending flag, update last-grant, return to IDLE.
  - Minimum latency: en at cycle 0 -> cyc at cycle 1 -> ack at cycle 1 -> valid at cycle 2.
- Back-to-back: one IDLE cycle (cyc low) between transfers. A new request for the completing port is accepted in its valid cycle.
- Watchdog:
  - Counter starts at 0 on bus entry and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, pulse that port's valid with rdata = 0, set o_timeout, go to IDLE.
  - o_timeout clears only on reset.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no flag.
- rdata holds its value until the next completion on the same port.
- Ack in IDLE is ignored. i_wb_data is sampled only on ack.
- Reset mid-transfer: cyc/stb drop the next cycle; no valid pulse; pending requests are lost.

Test Plan:
- Single fetch: code_en, addr 0x100; ack 2 cycles after stb with data 0x00000013 -> wb_addr 0x100, we 0, sel 0xF; one o_code_valid pulse, o_code_data = 0x00000013.
- Store: data_en, we=1, addr 0x2004, wdata 0xA5A5A5A5, strobe 0x3; immediate ack -> wb_we 1, sel 0x3, o_wb_data 0xA5A5A5A5; o_data_valid 1 cycle, rdata 0.
- Contention: code_en and data_en in the same cycle after reset, both then re-requested on completion -> grant order DATA, CODE, DATA, CODE; one idle cycle between cyc assertions.
- Timeout: TIMEOUT_CYCLES=8; load to 0x3000, never ack -> cyc falls after 8 wait cycles; o_data_valid pulse, rdata 0, o_timeout = 1 and stays 1.
- Ack on the timeout cycle: ack coincides with counter = TIMEOUT_CYCLES, data 0x1234 -> rdata 0x1234, o_timeout remains 0.
- Reset mid-cycle: rst_core during a code bus cycle -> next cycle cyc = stb = 0, no valid pulse, FSM IDLE; a fresh fetch then completes normally.
